// File: rtl/ripple_count_ctrl.sv
// ripple_count_ctrl: sequencer for an external asynchronous ripple counter.
// It clears the counter, issues `target` pulses and waits SETTLE cycles after
// each pulse so the ripple can settle. At each CHECK it compares the counter
// outputs with an internal shadow count.
//
// Command handshake: start is a strobe that is accepted only while busy=0 and
// abort=0. That accepted edge latches target. done pulses for exactly one cycle
// when the run ends normally or with an error. It is never asserted after an
// abort. busy is high from the cycle after the accepted start until the state
// machine returns to IDLE.
module ripple_count_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] target,
  output logic             cnt_pulse,
  output logic             cnt_clear,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR      = 3'd1,
    SETTLE_S = 3'd2,
    CHECK    = 3'd3,
    PULSE_HI = 3'd4,
    PULSE_LO = 3'd5,
    DONE     = 3'd6,
    ABORT    = 3'd7
  } state_t;

  // Timer reload: the state is held for SETTLE cycles, counting down to zero.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t           state, state_next;
  logic [3:0]       timer;
  logic [WIDTH-1:0] target_r;
  logic             start_acc;
  logic             abort_take;
  logic             set_err;

  assign state_dbg = state;

  // Next-state decode. Abort takes priority over every normal transition in the active states.
  always_comb begin
    state_next = state;
    start_acc  = 1'b0;
    abort_take = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          start_acc  = 1'b1;
          state_next = CLR;
        end
      end
      CLR:      state_next = SETTLE_S;
      SETTLE_S: if (timer == 4'd0) state_next = CHECK;
      CHECK: begin
        if (cnt_q != count) begin
          set_err    = 1'b1;
          state_next = DONE;
        end else if (count == target_r) begin
          state_next = DONE;
        end else begin
          state_next = PULSE_HI;
        end
      end
      PULSE_HI: state_next = PULSE_LO;
      PULSE_LO: state_next = SETTLE_S;
      DONE:     state_next = IDLE;
      ABORT:    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (abort && (state == CLR || state == SETTLE_S || state == CHECK ||
                  state == PULSE_HI || state == PULSE_LO)) begin
      abort_take = 1'b1;
      set_err    = 1'b0;
      state_next = ABORT;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_next;
  end

  // Settle timer: loaded on entry to SETTLE, counts down while in it.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      timer <= 4'd0;
    end else if (state_next == SETTLE_S && state != SETTLE_S) begin
      timer <= SETTLE_LOAD;
    end else if (state == SETTLE_S && timer != 4'd0) begin
      timer <= timer - 4'd1;
    end
  end

  // Target latch, shadow count and sticky error flag.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      target_r <= '0;
      count    <= '0;
      err      <= 1'b0;
    end else begin
      if (start_acc) target_r <= target;
      if (start_acc || abort_take) begin
        count <= '0;
      end else if (state_next == PULSE_LO && state != PULSE_LO) begin
        count <= count + WIDTH'(1);
      end
      if (start_acc)    err <= 1'b0;
      else if (set_err) err <= 1'b1;
    end
  end

  // Registered outputs decoded from the next state, so they never glitch.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt_pulse <= 1'b0;
      cnt_clear <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt_pulse <= (state_next == PULSE_HI);
      cnt_clear <= (state_next == CLR) || (state_next == ABORT);
      done      <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

endmodule
